// File: rtl/sync_filter_bank_pkg.sv
// Shared definitions for sync_filter_bank: edge_sel encodings, parameter range
// limits and the edge-match helper used by every channel.
package sync_pkg;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_NONE = 2'b11
   } edge_mode_e;

   localparam int WIDTH_MIN    = 1;
   localparam int WIDTH_MAX    = 32;
   localparam int STAGES_MIN   = 2;
   localparam int STAGES_MAX   = 4;
   localparam int FILT_LEN_MIN = 1;
   localparam int FILT_LEN_MAX = 255;

   // True when a transition old_lvl -> new_lvl is selected by mode.
   function automatic logic edge_hit(input logic [1:0] mode, input logic old_lvl,
                                     input logic new_lvl);
      logic hit;
      hit = 1'b0;
      case (mode)
         EDGE_RISE: hit = !old_lvl && new_lvl;
         EDGE_FALL: hit = old_lvl && !new_lvl;
         EDGE_BOTH: hit = old_lvl != new_lvl;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/sync_filter_bank_chan.sv
// One channel: STAGES-deep synchronizer, optional persistence filter
// (SYNC_FILTER_BANK_FILTER_EN), registered edge pulse and sticky event flag.
module sync_chan
   import sync_pkg::*;
#(
   parameter int STAGES = 2
`ifdef SYNC_FILTER_BANK_FILTER_EN
   , parameter int FILT_LEN = 4
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       async_in,
   input  logic [1:0] edge_sel,
   input  logic       clr,
   output logic       level_out,
   output logic       pulse_out,
   output logic       evt_flag
);

   logic [STAGES-1:0] sync_q;
   logic              s;
   logic              accept;
   logic              pulse_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else if (ena) begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
      end
   end

   assign s = sync_q[STAGES-1];

`ifdef SYNC_FILTER_BANK_FILTER_EN
   localparam int CW = $clog2(FILT_LEN + 1);
   logic [CW-1:0] cnt_q;

   // The FILT_LEN-th differing cycle accepts, so the counter never reaches FILT_LEN.
   assign accept = (s != level_out) && (cnt_q == CW'(FILT_LEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (ena) begin
         if (s == level_out || accept) cnt_q <= '0;
         else                          cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign accept = (s != level_out);
`endif

   assign pulse_d = accept && edge_hit(edge_sel, level_out, s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_out <= 1'b0;
         pulse_out <= 1'b0;
         evt_flag  <= 1'b0;
      end else if (ena) begin
         if (accept) level_out <= s;
         pulse_out <= pulse_d;
         evt_flag  <= pulse_d | (evt_flag & ~clr);
      end else begin
         pulse_out <= 1'b0;
      end
   end

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of WIDTH independent synchronizer/filter channels. Define
// SYNC_FILTER_BANK_FILTER_EN to build the FILT_LEN glitch filter.
module sync_filter_bank
   import sync_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STAGES   = 2,
   parameter int FILT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] async_in,
   input  logic [1:0]       edge_sel,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] pulse_out,
   output logic [WIDTH-1:0] evt_flag
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
       STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
       FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_params
      $error("sync_filter_bank: parameter out of range");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      sync_chan #(
         .STAGES(STAGES)
`ifdef SYNC_FILTER_BANK_FILTER_EN
         , .FILT_LEN(FILT_LEN)
`endif
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .ena       (ena),
         .async_in  (async_in[i]),
         .edge_sel  (edge_sel),
         .clr       (clr[i]),
         .level_out (level_out[i]),
         .pulse_out (pulse_out[i]),
         .evt_flag  (evt_flag[i])
      );
   end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Scoreboard bench for sync_filter_bank (WIDTH=8, STAGES=2, FILT_LEN=4); expected
// latencies follow SYNC_FILTER_BANK_FILTER_EN.
module tb_sync_filter_bank;
   import sync_pkg::*;

   localparam int W        = 8;
   localparam int STAGES   = 2;
   localparam int FILT_LEN = 4;
`ifdef SYNC_FILTER_BANK_FILTER_EN
   localparam int LAT = STAGES + FILT_LEN;
`else
   localparam int LAT = STAGES + 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b1;
   logic [W-1:0] async_in = '0;
   logic [1:0]   edge_sel = EDGE_RISE;
   logic [W-1:0] clr = '0;
   logic [W-1:0] level_out, pulse_out, evt_flag;

   sync_filter_bank #(.WIDTH(W), .STAGES(STAGES), .FILT_LEN(FILT_LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .async_in  (async_in),
      .edge_sel  (edge_sel),
      .clr       (clr),
      .level_out (level_out),
      .pulse_out (pulse_out),
      .evt_flag  (evt_flag)
   );

   // ---------------- clock / reset ----------------
   int cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   // record = {cycle[31:0], level, pulse, flag}
   logic [55:0]  exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] exp_level = '0;
   logic [W-1:0] exp_flag = '0;
   logic [W-1:0] prev_level = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] pulse_model(input logic [W-1:0] nv, input logic [W-1:0] ov,
                                                input logic [1:0] es);
      case (es)
         EDGE_RISE: return nv & ~ov;
         EDGE_FALL: return ~nv & ov;
         EDGE_BOTH: return nv ^ ov;
         default:   return '0;
      endcase
   endfunction

   // Monitor: any level change or pulse is a DUT output event.
   always @(negedge clk) begin
      logic [31:0]  rc;
      logic [W-1:0] rl, rp, rf;
      if (rst_n && (level_out !== prev_level || pulse_out !== '0)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event_level", {24'b0, level_out}, {24'b0, prev_level});
         end else begin
            {rc, rl, rp, rf} = exp_q.pop_front();
            chk("event_cycle", cyc, rc);
            chk("event_level", {24'b0, level_out}, {24'b0, rl});
            chk("event_pulse", {24'b0, pulse_out}, {24'b0, rp});
            chk("event_flag",  {24'b0, evt_flag},  {24'b0, rf});
         end
      end
      prev_level = level_out;
   end

   // ---------------- driver tasks ----------------
   // Apply a held step; optional ena gap and a clr aligned to the accept edge.
   task automatic step(input logic [W-1:0] val, input logic [1:0] es,
                       input logic [W-1:0] clrm, input int gap);
      int c;
      logic [W-1:0] p;
      @(negedge clk);
      async_in = val;
      edge_sel = es;
      c = cyc;
      p = pulse_model(val, exp_level, es);
      exp_flag = (exp_flag & ~clrm) | p;
      exp_level = val;
      exp_q.push_back({32'(c + LAT + gap), val, p, exp_flag});
      for (int k = 1; k < LAT + gap; k++) begin
         @(negedge clk);
         ena = !(gap > 0 && k >= 2 && k < 2 + gap);
         clr = (k == LAT + gap - 1) ? clrm : '0;
      end
      @(negedge clk);
      clr = '0;
      ena = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_only(input logic [W-1:0] m);
      @(negedge clk);
      clr = m;
      @(negedge clk);
      clr = '0;
      exp_flag = exp_flag & ~m;
      chk("flag_after_clr", {24'b0, evt_flag}, {24'b0, exp_flag});
      chk("pulse_after_clr", {24'b0, pulse_out}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;
      int d;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_level", {24'b0, level_out}, 32'h0);
      chk("reset_pulse", {24'b0, pulse_out}, 32'h0);
      chk("reset_flag",  {24'b0, evt_flag},  32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single-channel rising step
      step(8'h01, EDGE_RISE, 8'h00, 0);

      // glitch on channel 1
      @(negedge clk);
      c = cyc;
`ifdef SYNC_FILTER_BANK_FILTER_EN
      async_in = exp_level | 8'h02;
      repeat (3) @(negedge clk);
      async_in = exp_level;
      repeat (LAT + 4) @(negedge clk);
      chk("glitch_level", {24'b0, level_out}, {24'b0, exp_level});
      chk("glitch_pulse", {24'b0, pulse_out}, 32'h0);
      chk("glitch_flag",  {24'b0, evt_flag},  {24'b0, exp_flag});
`else
      async_in = exp_level | 8'h02;
      exp_flag = exp_flag | 8'h02;
      exp_q.push_back({32'(c + LAT), exp_level | 8'h02, 8'h02, exp_flag});
      exp_q.push_back({32'(c + LAT + 1), exp_level, 8'h00, exp_flag});
      @(negedge clk);
      async_in = exp_level;
      repeat (LAT + 4) @(negedge clk);
`endif

      // both edges, then no edges
      step(8'h81, EDGE_BOTH, 8'h00, 0);
      step(8'h01, EDGE_BOTH, 8'h00, 0);
      step(8'h81, EDGE_NONE, 8'h00, 0);
      step(8'h01, EDGE_NONE, 8'h00, 0);

      // sticky flag clear: alone, then coincident with a new pulse
      clear_only(8'h01);
      step(8'h00, EDGE_FALL, 8'h01, 0);
      chk("flag_set_wins", {31'b0, evt_flag[0]}, 32'h1);
      clear_only(8'h01);

      // multi-channel simultaneous step
      step(8'h5A, EDGE_RISE, 8'h00, 0);
      step(8'h00, EDGE_BOTH, 8'h00, 0);

      // reset mid-filter, then full latency again
      @(negedge clk);
      async_in = 8'h10;
      edge_sel = EDGE_RISE;
      repeat (LAT - 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_level", {24'b0, level_out}, 32'h0);
      chk("midreset_pulse", {24'b0, pulse_out}, 32'h0);
      chk("midreset_flag",  {24'b0, evt_flag},  32'h0);
      exp_level = '0;
      exp_flag = '0;
      @(negedge clk);
      rst_n = 1'b1;
      d = cyc;
      exp_level = 8'h10;
      exp_flag = 8'h10;
      exp_q.push_back({32'(d + LAT), 8'h10, 8'h10, 8'h10});
      repeat (LAT + 2) @(negedge clk);

      // ena low for 5 cycles mid-count
      step(8'h00, EDGE_FALL, 8'h00, 5);

      repeat (4) @(negedge clk);
      chk("events_outstanding", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
